// File: rtl/seg7_scan_if.sv
// seg7_scan_if: scanned 7-segment bus plus reconstructed word.
//   seg/dig_en       : scanned segment pattern and one-hot digit select (master -> slave)
//   value/valid/frame_err : captured word, publish pulse, bad-pattern flag (slave -> master)
interface seg7_scan_if #(parameter int DIGITS = 4);
  logic [6:0] seg;
  logic [DIGITS-1:0] dig_en;
  logic [4*DIGITS-1:0] value;
  logic valid;
  logic frame_err;
  modport master(output seg, dig_en, input value, valid, frame_err);
  modport slave(input seg, dig_en, output value, valid, frame_err);
endinterface

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: rebuilds the hex word shown on a scanned 7-segment display.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of seg7_scan_if (seg/dig_en in; value/valid/frame_err out)
module seg7_scan_capture #(
  parameter int DIGITS = 4,
  parameter int STABLE_CYCLES = 4
) (
  input logic clk,
  input logic rst,
  seg7_scan_if.slave bus
);
  localparam int CW = $clog2(STABLE_CYCLES);
  typedef enum logic {WAIT, HOLD} state_t;
  state_t state, state_next;
  logic [DIGITS+6:0] pair, pair_q;
  logic [CW-1:0] cnt;
  logic [DIGITS-1:0] seen, err;
  logic [4*DIGITS-1:0] slots, value;
  logic same, onehot, stable, accept, pub, bad, valid, frame_err;
  logic [3:0] nib;
  assign pair = {bus.dig_en, bus.seg};
  assign same = pair == pair_q;
  assign onehot = bus.dig_en != '0 && (bus.dig_en & (bus.dig_en - DIGITS'(1))) == '0;
  // the counter steps to STABLE_CYCLES-1 on this edge, i.e. the STABLE_CYCLES-th identical sample
  assign stable = same && cnt == CW'(STABLE_CYCLES - 2);
  assign bus.value = value;
  assign bus.valid = valid;
  assign bus.frame_err = frame_err;
  always_comb begin
    state_next = state == WAIT ? (stable ? HOLD : WAIT) : (same ? HOLD : WAIT);
    accept = state == WAIT && stable && onehot;
  end
  always_comb begin
    nib = 4'h0;
    bad = 1'b0;
    case (bus.seg)
      7'h7E: nib = 4'h0;
      7'h30: nib = 4'h1;
      7'h6D: nib = 4'h2;
      7'h79: nib = 4'h3;
      7'h33: nib = 4'h4;
      7'h5B: nib = 4'h5;
      7'h5F: nib = 4'h6;
      7'h70: nib = 4'h7;
      7'h7F: nib = 4'h8;
      7'h7B: nib = 4'h9;
      7'h77: nib = 4'hA;
      7'h1F: nib = 4'hB;
      7'h4E: nib = 4'hC;
      7'h3D: nib = 4'hD;
      7'h4F: nib = 4'hE;
      7'h47: nib = 4'hF;
      default: bad = 1'b1;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT;
      pair_q <= '0;
      cnt <= '0;
      seen <= '0;
      err <= '0;
      slots <= '0;
      pub <= 1'b0;
      value <= '0;
      valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state <= state_next;
      pair_q <= pair;
      cnt <= !same ? '0 : cnt == CW'(STABLE_CYCLES - 1) ? cnt : cnt + CW'(1);
      pub <= accept && &(seen | bus.dig_en);
      valid <= pub;
      // a publish edge never coincides with an accept: an accept is always followed by a HOLD cycle
      if (pub) begin
        value <= slots;
        frame_err <= |err;
        seen <= '0;
        err <= '0;
      end else if (accept) begin
        seen <= seen | bus.dig_en;
        err <= bad ? err | bus.dig_en : err & ~bus.dig_en;
      end
      for (int i = 0; i < DIGITS; i++)
        if (accept && bus.dig_en[i]) slots[4*i +: 4] <= nib;
    end
  end
endmodule
